// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master between NUM_REQ requesters.
// Optional wait-state timeout abort: define APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STROBE_WIDTH   = 4,
  parameter int SLAVES_NUM     = 2,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*SLAVES_NUM-1:0]   req_sel,
  input  logic [NUM_REQ*STROBE_WIDTH-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0]            req_prot,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err,
  output logic                            Transfer,
  output logic [ADDR_WIDTH-1:0]           ADDR_in,
  output logic [DATA_WIDTH-1:0]           DATA_in,
  output logic                            WRITE_in,
  output logic [SLAVES_NUM-1:0]           SEL_in,
  output logic [STROBE_WIDTH-1:0]         STROB_in,
  output logic [2:0]                      PROT_in,
  input  logic [SLAVES_NUM-1:0]           PSEL,
  input  logic                            PENABLE,
  input  logic                            PREADY,
  input  logic                            PSLVERR,
  input  logic [DATA_WIDTH-1:0]           PRDATA,
  output logic [GW-1:0]                   gnt_id
);

  // state    | meaning
  // ARB_IDLE | no command held; grant next valid requester round-robin
  // ARB_BUSY | command presented to master, waiting for APB completion
  // ARB_RESP | one-cycle response pulse to granted requester
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} state_t;

  state_t                  state, state_next;
  logic [GW-1:0]           ptr, gnt_next;
  logic                    any_valid, done, timeout;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    sel_write;
  logic [SLAVES_NUM-1:0]   sel_sel;
  logic [STROBE_WIDTH-1:0] sel_strb;
  logic [2:0]              sel_prot;

  // First valid requester at or after the pointer, ascending with wrap.
  always_comb begin
    int gidx;
    int idx;
    logic found;
    found    = 1'b0;
    gidx     = int'(ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    any_valid = found;
    gnt_next  = GW'(gidx);
    sel_addr  = req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
    sel_write = req_write[gidx];
    sel_sel   = req_sel[gidx*SLAVES_NUM +: SLAVES_NUM];
    sel_strb  = req_strb[gidx*STROBE_WIDTH +: STROBE_WIDTH];
    sel_prot  = req_prot[gidx*3 +: 3];
  end

  assign done = (|PSEL) & PENABLE & PREADY;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] wait_cnt;

  assign timeout = (wait_cnt == TCW'(TIMEOUT_CYCLES));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)
      wait_cnt <= '0;
    else if (state != ARB_BUSY)
      wait_cnt <= '0;
    else if (PENABLE && !PREADY && !timeout)
      wait_cnt <= wait_cnt + TCW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  // Dropping Transfer in the completion cycle sends the master back to IDLE.
  assign Transfer  = (state == ARB_BUSY) & ~done & ~timeout;
  assign rsp_valid = (state == ARB_RESP) ? (NUM_REQ'(1) << gnt_id) : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= ARB_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: if (any_valid) state_next = ARB_BUSY;
      ARB_BUSY: if (done || timeout) state_next = ARB_RESP;
      ARB_RESP: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      req_ready <= '0;
      gnt_id    <= '0;
      ptr       <= '0;
      ADDR_in   <= '0;
      DATA_in   <= '0;
      WRITE_in  <= 1'b0;
      SEL_in    <= '0;
      STROB_in  <= '0;
      PROT_in   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= '0;
      if (state == ARB_IDLE && any_valid) begin
        req_ready[gnt_next] <= 1'b1;
        gnt_id   <= gnt_next;
        ADDR_in  <= sel_addr;
        DATA_in  <= sel_wdata;
        WRITE_in <= sel_write;
        SEL_in   <= sel_sel;
        STROB_in <= sel_strb;
        PROT_in  <= sel_prot;
      end
      if (state == ARB_BUSY) begin
        if (done) begin
          rsp_rdata <= WRITE_in ? '0 : PRDATA;
          rsp_err   <= PSLVERR;
        end else if (timeout) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
      if (state == ARB_RESP)
        ptr <= (gnt_id == GW'(NUM_REQ - 1)) ? '0 : gnt_id + GW'(1);
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a behavioural APB master and slave.
// Timeout scenario runs only when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_req_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_write = '0;
  logic [3:0]  req_sel = '0;
  logic [7:0]  req_strb = '0;
  logic [5:0]  req_prot = '0;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        Transfer;
  logic [31:0] ADDR_in, DATA_in;
  logic        WRITE_in;
  logic [1:0]  SEL_in;
  logic [3:0]  STROB_in;
  logic [2:0]  PROT_in;
  logic [1:0]  PSEL;
  logic        PENABLE, PREADY, PSLVERR;
  logic [31:0] PRDATA;
  logic [0:0]  gnt_id;

  int checks = 0;
  int failures = 0;

  int          slv_wait = 0;
  logic        slv_hang = 1'b0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = '0;

  always #5 PCLK = ~PCLK;

  apb_req_arbiter dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
    .req_sel(req_sel), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Transfer(Transfer), .ADDR_in(ADDR_in), .DATA_in(DATA_in),
    .WRITE_in(WRITE_in), .SEL_in(SEL_in), .STROB_in(STROB_in), .PROT_in(PROT_in),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PRDATA(PRDATA), .gnt_id(gnt_id)
  );

  // Behavioural APB master: IDLE -> SETUP -> ACCESS, aborts if Transfer drops.
  typedef enum logic [1:0] {M_IDLE, M_SETUP, M_ACCESS} mst_t;
  mst_t mst;
  int   wcnt;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) mst <= M_IDLE;
    else case (mst)
      M_IDLE:   if (Transfer) mst <= M_SETUP;
      M_SETUP:  mst <= M_ACCESS;
      M_ACCESS: if (PREADY) mst <= Transfer ? M_SETUP : M_IDLE;
                else if (!Transfer) mst <= M_IDLE;
      default:  mst <= M_IDLE;
    endcase
  end

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) wcnt <= 0;
    else if (mst == M_ACCESS && !PREADY) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign PSEL    = (mst != M_IDLE) ? SEL_in : 2'b00;
  assign PENABLE = (mst == M_ACCESS);
  assign PREADY  = (mst == M_ACCESS) && !slv_hang && (wcnt >= slv_wait);
  assign PSLVERR = PREADY && slv_err;
  assign PRDATA  = slv_rdata;

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] s,
                         input logic [3:0] st, input logic [2:0] p);
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = d;
    req_write[i] = wr;
    req_sel[i*2 +: 2] = s;
    req_strb[i*4 +: 4] = st;
    req_prot[i*3 +: 3] = p;
  endtask

  // Raise valid for requester i, drop it on accept, wait for the response.
  // lat is the cycle number (accept edge = edge 0) in which rsp_valid appears.
  task automatic run_one(input int i, output logic [1:0] rv, output logic [31:0] rd,
                         output logic e, output int lat, output bit ok);
    int n;
    ok = 1'b1; rv = '0; rd = '0; e = 1'b0; lat = 0; n = 0;
    req_valid[i] = 1'b1;
    do begin tick; n++; end while (req_ready[i] !== 1'b1 && n < 20);
    if (req_ready[i] !== 1'b1) ok = 1'b0;
    req_valid[i] = 1'b0;
    lat = 1;
    do begin tick; lat++; end while (rsp_valid === 2'b00 && lat < 200);
    if (rsp_valid === 2'b00) ok = 1'b0;
    rv = rsp_valid; rd = rsp_rdata; e = rsp_err;
  endtask

  task automatic do_reset;
    PRESETn = 1'b0;
    tick; tick;
    PRESETn = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    PRESETn = 1'b0;
    req_valid = 2'b01;
    set_req(0, 1'b1, 32'h55, 32'h66, 2'b01, 4'hF, 3'b111);
    tick; tick;
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || Transfer !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: ready=%b rsp_valid=%b Transfer=%b, want 00 00 0",
               req_ready, rsp_valid, Transfer);
    end
    checks++;
    if (ADDR_in !== 0 || DATA_in !== 0 || WRITE_in !== 0 || SEL_in !== 0 ||
        STROB_in !== 0 || PROT_in !== 0 || gnt_id !== 0 || rsp_rdata !== 0 || rsp_err !== 0) begin
      failures++;
      $display("FAIL reset_regs: addr=%h data=%h wr=%b sel=%b strb=%h prot=%b gnt=%0d rdata=%h err=%b, want all 0",
               ADDR_in, DATA_in, WRITE_in, SEL_in, STROB_in, PROT_in, gnt_id, rsp_rdata, rsp_err);
    end
    req_valid = 2'b00;
    PRESETn = 1'b1;
    tick;
  endtask

  task automatic test_write_zero_wait;
    set_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b01, 4'hF, 3'b000);
    slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'hA5A5_A5A5;
    req_valid = 2'b01;
    tick;  // cycle 1
    checks++;
    if (req_ready !== 2'b01 || gnt_id !== 1'b0 || Transfer !== 1'b1) begin
      failures++;
      $display("FAIL wr_accept: ready=%b gnt=%0d Transfer=%b, want 01 0 1", req_ready, gnt_id, Transfer);
    end
    checks++;
    if (ADDR_in !== 32'h10 || DATA_in !== 32'hDEAD_BEEF || WRITE_in !== 1'b1 ||
        SEL_in !== 2'b01 || STROB_in !== 4'hF) begin
      failures++;
      $display("FAIL wr_cmd: addr=%h data=%h wr=%b sel=%b strb=%h, want 10 deadbeef 1 01 f",
               ADDR_in, DATA_in, WRITE_in, SEL_in, STROB_in);
    end
    req_valid = 2'b00;
    tick;  // cycle 2
    checks++;
    if (PSEL !== 2'b01 || PENABLE !== 1'b0 || req_ready !== 2'b00 || Transfer !== 1'b1) begin
      failures++;
      $display("FAIL wr_setup: PSEL=%b PENABLE=%b ready=%b Transfer=%b, want 01 0 00 1",
               PSEL, PENABLE, req_ready, Transfer);
    end
    tick;  // cycle 3
    checks++;
    if (PENABLE !== 1'b1 || Transfer !== 1'b0) begin
      failures++;
      $display("FAIL wr_access: PENABLE=%b Transfer=%b, want 1 0", PENABLE, Transfer);
    end
    tick;  // cycle 4
    checks++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL wr_resp: rsp_valid=%b err=%b rdata=%h, want 01 0 0", rsp_valid, rsp_err, rsp_rdata);
    end
    tick;  // cycle 5
    checks++;
    if (rsp_valid !== 2'b00 || Transfer !== 1'b0) begin
      failures++;
      $display("FAIL wr_resp_pulse: rsp_valid=%b Transfer=%b, want 00 0", rsp_valid, Transfer);
    end
  endtask

  task automatic test_read_wait_states;
    set_req(1, 1'b0, 32'h0000_0020, 32'h0, 2'b10, 4'h0, 3'b010);
    slv_wait = 3; slv_rdata = 32'h1234_5678;
    req_valid = 2'b10;
    tick;  // cycle 1
    checks++;
    if (req_ready !== 2'b10 || gnt_id !== 1'b1 || PROT_in !== 3'b010 || WRITE_in !== 1'b0) begin
      failures++;
      $display("FAIL rd_accept: ready=%b gnt=%0d prot=%b wr=%b, want 10 1 010 0",
               req_ready, gnt_id, PROT_in, WRITE_in);
    end
    req_valid = 2'b00;
    for (int c = 2; c <= 6; c++) begin
      tick;
      checks++;
      if (Transfer !== (c != 6) || rsp_valid !== 2'b00) begin
        failures++;
        $display("FAIL rd_wait_c%0d: Transfer=%b rsp_valid=%b, want %b 00", c, Transfer, rsp_valid, (c != 6));
      end
    end
    tick;  // cycle 7
    checks++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rd_resp: rsp_valid=%b rdata=%h err=%b, want 10 12345678 0", rsp_valid, rsp_rdata, rsp_err);
    end
    tick;
    slv_wait = 0;
  endtask

  task automatic test_back_to_back;
    int n;
    do_reset;
    set_req(0, 1'b1, 32'h100, 32'h1111_0000, 2'b01, 4'h3, 3'b000);
    set_req(1, 1'b0, 32'h200, 32'h0, 2'b10, 4'h0, 3'b001);
    slv_rdata = 32'h0000_BEEF;
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      do begin tick; n++; end while (rsp_valid === 2'b00 && n < 30);
      checks++;
      if (rsp_valid !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL b2b_order_%0d: rsp_valid=%b, want %b", t, rsp_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick;
      checks++;
      if (Transfer !== 1'b0 || PSEL !== 2'b00) begin
        failures++;
        $display("FAIL b2b_idle_%0d: Transfer=%b PSEL=%b, want 0 00", t, Transfer, PSEL);
      end
      if (t < 3) begin
        tick;
        checks++;
        if (Transfer !== 1'b1 || gnt_id !== ((t % 2 == 0) ? 1'b1 : 1'b0)) begin
          failures++;
          $display("FAIL b2b_next_%0d: Transfer=%b gnt=%0d, want 1 %0d", t, Transfer, gnt_id, (t + 1) % 2);
        end
      end
    end
    req_valid = 2'b00;
    tick; tick;
  endtask

  task automatic test_slave_error;
    logic [1:0] rv; logic [31:0] rd; logic e; int lat; bit ok;
    set_req(0, 1'b0, 32'h30, 32'h0, 2'b01, 4'h0, 3'b000);
    slv_err = 1'b1; slv_rdata = 32'hCAFE_0001; slv_wait = 0;
    run_one(0, rv, rd, e, lat, ok);
    checks++;
    if (!ok || rv !== 2'b01 || e !== 1'b1 || rd !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL err_resp: ok=%0d rsp_valid=%b err=%b rdata=%h, want 1 01 1 cafe0001", ok, rv, e, rd);
    end
    slv_err = 1'b0; slv_rdata = 32'h0BAD_F00D;
    set_req(1, 1'b0, 32'h40, 32'h0, 2'b10, 4'h0, 3'b000);
    tick;
    run_one(1, rv, rd, e, lat, ok);
    checks++;
    if (!ok || rv !== 2'b10 || e !== 1'b0 || rd !== 32'h0BAD_F00D || lat != 4) begin
      failures++;
      $display("FAIL err_recover: ok=%0d rsp_valid=%b err=%b rdata=%h lat=%0d, want 1 10 0 0badf00d 4",
               ok, rv, e, rd, lat);
    end
    tick;
  endtask

  task automatic test_mid_reset;
    logic [1:0] rv; logic [31:0] rd; logic e; int lat; bit ok;
    int seen;
    set_req(0, 1'b0, 32'h50, 32'h0, 2'b01, 4'h0, 3'b000);
    slv_wait = 100;
    req_valid = 2'b01;
    tick;
    req_valid = 2'b00;
    tick; tick;  // cycle 3, ACCESS with PREADY low
    checks++;
    if (Transfer !== 1'b1 || PENABLE !== 1'b1) begin
      failures++;
      $display("FAIL mrst_busy: Transfer=%b PENABLE=%b, want 1 1", Transfer, PENABLE);
    end
    PRESETn = 1'b0;
    #1;
    checks++;
    if (Transfer !== 1'b0 || rsp_valid !== 2'b00 || ADDR_in !== 0 || SEL_in !== 0 || PSEL !== 0) begin
      failures++;
      $display("FAIL mrst_clear: Transfer=%b rsp_valid=%b addr=%h sel=%b PSEL=%b, want 0 00 0 00 00",
               Transfer, rsp_valid, ADDR_in, SEL_in, PSEL);
    end
    seen = 0;
    tick; if (rsp_valid !== 2'b00) seen++;
    tick; if (rsp_valid !== 2'b00) seen++;
    PRESETn = 1'b1;
    slv_wait = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (rsp_valid !== 2'b00) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mrst_no_rsp: rsp_valid pulses=%0d, want 0", seen);
    end
    set_req(1, 1'b1, 32'h60, 32'h7777_7777, 2'b10, 4'hC, 3'b100);
    run_one(1, rv, rd, e, lat, ok);
    checks++;
    if (!ok || rv !== 2'b10 || e !== 1'b0 || rd !== 32'h0 || lat != 4) begin
      failures++;
      $display("FAIL mrst_after: ok=%0d rsp_valid=%b err=%b rdata=%h lat=%0d, want 1 10 0 0 4",
               ok, rv, e, rd, lat);
    end
    tick;
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout;
    set_req(0, 1'b0, 32'h70, 32'h0, 2'b01, 4'h0, 3'b000);
    slv_hang = 1'b1; slv_rdata = 32'hFFFF_FFFF;
    req_valid = 2'b01;
    tick;  // cycle 1
    req_valid = 2'b00;
    for (int c = 2; c <= 19; c++) begin
      tick;
      checks++;
      if (Transfer !== (c != 19) || rsp_valid !== 2'b00) begin
        failures++;
        $display("FAIL to_wait_c%0d: Transfer=%b rsp_valid=%b, want %b 00", c, Transfer, rsp_valid, (c != 19));
      end
    end
    tick;  // cycle 20
    checks++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || PSEL !== 2'b00) begin
      failures++;
      $display("FAIL to_resp: rsp_valid=%b err=%b rdata=%h PSEL=%b, want 01 1 0 00",
               rsp_valid, rsp_err, rsp_rdata, PSEL);
    end
    slv_hang = 1'b0;
    tick;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write_zero_wait;
    test_read_wait_states;
    test_back_to_back;
    test_slave_error;
    test_mid_reset;
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
